rf_multiport: RTL and testbench

Parametrised architectural register file and rename-status table for the out-of-order core. It serves a superscalar dispatch bundle of DISP_W instructions and retires up to CMT_W ROB entries per cycle. Each register holds a committed value and a producer ROB tag. Sits between decoder/dispatch, ROB commit and the IF jalr target path.

---
 rtl/rf_multiport_if.sv | 40 ++++
 rtl/rf_multiport.sv | 156 +++++++++++++++
 tb/tb_rf_multiport.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_multiport_if.sv
// Dispatch, commit and jalr-lookup bundle between the pipeline and the
// architectural register file / rename-status table.
interface rf_multiport_if #(
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int ROB_W  = 4,
  parameter int DISP_W = 2,
  parameter int CMT_W  = 2
);
  logic                          rdy_in;
  logic                          flush_in;
  logic [CMT_W-1:0]              cmt_valid;
  logic [CMT_W*REG_W-1:0]        cmt_rd;
  logic [CMT_W*XLEN-1:0]         cmt_value;
  logic [CMT_W*(ROB_W+1)-1:0]    cmt_tag;
  logic [DISP_W-1:0]             disp_valid;
  logic [DISP_W*REG_W-1:0]       disp_rd;
  logic [DISP_W*REG_W-1:0]       disp_rs1;
  logic [DISP_W*REG_W-1:0]       disp_rs2;
  logic [DISP_W*(ROB_W+1)-1:0]   disp_tag;
  logic [DISP_W*XLEN-1:0]        src1_value;
  logic [DISP_W*XLEN-1:0]        src2_value;
  logic [DISP_W*(ROB_W+1)-1:0]   src1_tag;
  logic [DISP_W*(ROB_W+1)-1:0]   src2_tag;
  logic [REG_W-1:0]              jalr_rs_in;
  logic [XLEN-1:0]               jalr_value_out;
  logic [ROB_W:0]                jalr_tag_out;

  modport master (
    output rdy_in, flush_in, cmt_valid, cmt_rd, cmt_value, cmt_tag,
           disp_valid, disp_rd, disp_rs1, disp_rs2, disp_tag, jalr_rs_in,
    input  src1_value, src2_value, src1_tag, src2_tag, jalr_value_out, jalr_tag_out
  );

  modport slave (
    input  rdy_in, flush_in, cmt_valid, cmt_rd, cmt_value, cmt_tag,
           disp_valid, disp_rd, disp_rs1, disp_rs2, disp_tag, jalr_rs_in,
    output src1_value, src2_value, src1_tag, src2_tag, jalr_value_out, jalr_tag_out
  );
endinterface

// File: rtl/rf_multiport.sv
// Architectural register file with per-register producer ROB tag; combinational
// operand reads with dispatch and commit bypass, one-cycle registered updates.
module rf_multiport #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int REG_W   = 5,
  parameter int ROB_W   = 4,
  parameter int DISP_W  = 2,
  parameter int CMT_W   = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  rf_multiport_if.slave  bus
);
  localparam int TAG_W = ROB_W + 1;
  localparam logic [TAG_W-1:0] TAG_READY = {TAG_W{1'b1}};
  localparam logic [REG_W-1:0] REG_ZERO  = {REG_W{1'b0}};
  localparam logic [XLEN-1:0]  VAL_ZERO  = {XLEN{1'b0}};

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [TAG_W-1:0] tag;
  } rd_res_t;

  logic [XLEN-1:0]  r_value [REG_NUM];
  logic [TAG_W-1:0] r_tag   [REG_NUM];

  logic             w_cmt_valid  [CMT_W];
  logic [REG_W-1:0] w_cmt_rd     [CMT_W];
  logic [XLEN-1:0]  w_cmt_value  [CMT_W];
  logic [TAG_W-1:0] w_cmt_tag    [CMT_W];
  logic             w_disp_valid [DISP_W];
  logic [REG_W-1:0] w_disp_rd    [DISP_W];
  logic [REG_W-1:0] w_disp_rs1   [DISP_W];
  logic [REG_W-1:0] w_disp_rs2   [DISP_W];
  logic [TAG_W-1:0] w_disp_tag   [DISP_W];
  logic [XLEN-1:0]  w_value_nxt  [REG_NUM];
  logic [TAG_W-1:0] w_tag_nxt    [REG_NUM];

  logic [DISP_W*XLEN-1:0]  w_src1_value;
  logic [DISP_W*XLEN-1:0]  w_src2_value;
  logic [DISP_W*TAG_W-1:0] w_src1_tag;
  logic [DISP_W*TAG_W-1:0] w_src2_tag;
  rd_res_t                 w_jalr;

  always_comb begin
    for (int c = 0; c < CMT_W; c++) begin
      w_cmt_valid[c] = bus.cmt_valid[c];
      w_cmt_rd[c]    = bus.cmt_rd[c*REG_W +: REG_W];
      w_cmt_value[c] = bus.cmt_value[c*XLEN +: XLEN];
      w_cmt_tag[c]   = bus.cmt_tag[c*TAG_W +: TAG_W];
    end
    for (int k = 0; k < DISP_W; k++) begin
      w_disp_valid[k] = bus.disp_valid[k];
      w_disp_rd[k]    = bus.disp_rd[k*REG_W +: REG_W];
      w_disp_rs1[k]   = bus.disp_rs1[k*REG_W +: REG_W];
      w_disp_rs2[k]   = bus.disp_rs2[k*REG_W +: REG_W];
      w_disp_tag[k]   = bus.disp_tag[k*TAG_W +: TAG_W];
    end
  end

  // Committed view of a register: stored state overlaid with this cycle's retirements.
  function automatic rd_res_t arch_lookup(input logic [REG_W-1:0] rs);
    rd_res_t res;
    logic    clr;
    res.value = r_value[rs];
    res.tag   = r_tag[rs];
    clr       = 1'b0;
    for (int c = 0; c < CMT_W; c++) begin
      res.value = (w_cmt_valid[c] && (w_cmt_rd[c] == rs)) ? w_cmt_value[c] : res.value;
      clr       = clr | (w_cmt_valid[c] && (w_cmt_rd[c] == rs) && (r_tag[rs] == w_cmt_tag[c]));
    end
    res.tag   = clr ? TAG_READY : res.tag;
    res.value = (rs == REG_ZERO) ? VAL_ZERO : res.value;
    res.tag   = (rs == REG_ZERO) ? TAG_READY : res.tag;
    return res;
  endfunction

  always_comb begin
    rd_res_t          res;
    logic [REG_W-1:0] rs;
    logic             hit;
    res          = '{value: VAL_ZERO, tag: TAG_READY};
    rs           = REG_ZERO;
    hit          = 1'b0;
    w_src1_value = {(DISP_W*XLEN){1'b0}};
    w_src2_value = {(DISP_W*XLEN){1'b0}};
    w_src1_tag   = {(DISP_W*TAG_W){1'b0}};
    w_src2_tag   = {(DISP_W*TAG_W){1'b0}};
    for (int k = 0; k < DISP_W; k++) begin
      for (int o = 0; o < 2; o++) begin
        rs  = (o == 0) ? w_disp_rs1[k] : w_disp_rs2[k];
        res = arch_lookup(rs);
        // Older slots in the bundle rename rs; the youngest one wins.
        for (int j = 0; j < DISP_W; j++) begin
          hit       = (j < k) && w_disp_valid[j] && (w_disp_rd[j] == rs) && (w_disp_rd[j] != REG_ZERO);
          res.tag   = hit ? w_disp_tag[j] : res.tag;
          res.value = hit ? VAL_ZERO : res.value;
        end
        if (o == 0) begin
          w_src1_value[k*XLEN +: XLEN]  = res.value;
          w_src1_tag[k*TAG_W +: TAG_W]  = res.tag;
        end else begin
          w_src2_value[k*XLEN +: XLEN]  = res.value;
          w_src2_tag[k*TAG_W +: TAG_W]  = res.tag;
        end
      end
    end
  end

  always_comb begin
    logic clr;
    clr = 1'b0;
    for (int r = 0; r < REG_NUM; r++) begin
      w_value_nxt[r] = r_value[r];
      w_tag_nxt[r]   = r_tag[r];
      clr            = 1'b0;
      for (int c = 0; c < CMT_W; c++) begin
        w_value_nxt[r] = (w_cmt_valid[c] && (w_cmt_rd[c] == REG_W'(r))) ? w_cmt_value[c] : w_value_nxt[r];
        clr = clr | (w_cmt_valid[c] && (w_cmt_rd[c] == REG_W'(r)) && (r_tag[r] == w_cmt_tag[c]));
      end
      w_tag_nxt[r] = clr ? TAG_READY : w_tag_nxt[r];
      // A new producer allocated this cycle supersedes a retirement clear.
      for (int j = 0; j < DISP_W; j++) begin
        w_tag_nxt[r] = (w_disp_valid[j] && (w_disp_rd[j] == REG_W'(r))) ? w_disp_tag[j] : w_tag_nxt[r];
      end
      w_tag_nxt[r]   = (bus.flush_in || (r == 0)) ? TAG_READY : w_tag_nxt[r];
      w_value_nxt[r] = (r == 0) ? VAL_ZERO : w_value_nxt[r];
    end
  end

  always_comb begin
    w_jalr = arch_lookup(bus.jalr_rs_in);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_value[i] <= VAL_ZERO;
        r_tag[i]   <= TAG_READY;
      end
    end else if (bus.rdy_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_value[i] <= w_value_nxt[i];
        r_tag[i]   <= w_tag_nxt[i];
      end
    end
  end

  assign bus.src1_value     = w_src1_value;
  assign bus.src2_value     = w_src2_value;
  assign bus.src1_tag       = w_src1_tag;
  assign bus.src2_tag       = w_src2_tag;
  assign bus.jalr_value_out = w_jalr.value;
  assign bus.jalr_tag_out   = w_jalr.tag;
endmodule

// File: tb/tb_rf_multiport.sv
// Directed vector table plus randomized traffic against a rule-level reference
// model of the register file and rename-status table.
module tb_rf_multiport;
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  rf_multiport_if #(.XLEN(32), .REG_W(5), .ROB_W(4), .DISP_W(2), .CMT_W(2)) bus ();

  rf_multiport #(.XLEN(32), .REG_NUM(32), .REG_W(5), .ROB_W(4), .DISP_W(2), .CMT_W(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  typedef struct {
    logic        rdy;
    logic        flush;
    logic        cv   [2];
    logic [4:0]  crd  [2];
    logic [31:0] cval [2];
    logic [4:0]  ctag [2];
    logic        dv   [2];
    logic [4:0]  drd  [2];
    logic [4:0]  rs1  [2];
    logic [4:0]  rs2  [2];
    logic [4:0]  dtag [2];
    logic [4:0]  jrs;
    int          sel;   // 0 s0.rs1, 1 s0.rs2, 2 s1.rs1, 3 s1.rs2, 4 jalr
    logic [31:0] ev;
    logic [4:0]  et;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mval [32];
  logic [4:0]  mtag [32];
  vec_t        tbl  [$];

  function automatic vec_t blank();
    vec_t v;
    v.rdy = 1'b1; v.flush = 1'b0; v.jrs = 5'd0; v.sel = 0; v.ev = 32'd0; v.et = 5'h1F;
    for (int i = 0; i < 2; i++) begin
      v.cv[i] = 1'b0; v.crd[i] = 5'd0; v.cval[i] = 32'd0; v.ctag[i] = 5'd0;
      v.dv[i] = 1'b0; v.drd[i] = 5'd0; v.rs1[i] = 5'd0; v.rs2[i] = 5'd0; v.dtag[i] = 5'd0;
    end
    return v;
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    v = blank();
    v.rdy   = ($urandom_range(7) != 0);
    v.flush = ($urandom_range(15) == 0);
    v.jrs   = 5'($urandom_range(7));
    for (int i = 0; i < 2; i++) begin
      v.cv[i]   = 1'($urandom_range(1));
      v.crd[i]  = 5'($urandom_range(7));
      v.cval[i] = $urandom;
      v.ctag[i] = 5'($urandom_range(7));
      v.dv[i]   = 1'($urandom_range(1));
      v.drd[i]  = 5'($urandom_range(7));
      v.dtag[i] = 5'($urandom_range(7));
      v.rs1[i]  = 5'($urandom_range(7));
      v.rs2[i]  = 5'($urandom_range(7));
    end
    return v;
  endfunction

  // Reference read: zero register, then youngest older dispatch, then newest commit, then storage.
  function automatic logic [36:0] mread(input vec_t v, input int k, input logic [4:0] rs, input bit use_disp);
    logic [31:0] val;
    logic [4:0]  tg;
    bit          done;
    val = mval[rs]; tg = mtag[rs]; done = 1'b0;
    for (int c = 1; c >= 0; c--)
      if (!done && v.cv[c] && v.crd[c] == rs) begin val = v.cval[c]; done = 1'b1; end
    for (int c = 0; c < 2; c++)
      if (v.cv[c] && v.crd[c] == rs && mtag[rs] == v.ctag[c]) tg = 5'h1F;
    done = 1'b0;
    if (use_disp)
      for (int j = k - 1; j >= 0; j--)
        if (!done && v.dv[j] && v.drd[j] == rs) begin val = 32'd0; tg = v.dtag[j]; done = 1'b1; end
    if (rs == 5'd0) begin val = 32'd0; tg = 5'h1F; end
    return {val, tg};
  endfunction

  function automatic logic [36:0] model_out(input vec_t v, input int sel);
    case (sel)
      0:       return mread(v, 0, v.rs1[0], 1'b1);
      1:       return mread(v, 0, v.rs2[0], 1'b1);
      2:       return mread(v, 1, v.rs1[1], 1'b1);
      3:       return mread(v, 1, v.rs2[1], 1'b1);
      default: return mread(v, 0, v.jrs, 1'b0);
    endcase
  endfunction

  function automatic logic [36:0] dut_out(input int sel);
    case (sel)
      0:       return {bus.src1_value[31:0],  bus.src1_tag[4:0]};
      1:       return {bus.src2_value[31:0],  bus.src2_tag[4:0]};
      2:       return {bus.src1_value[63:32], bus.src1_tag[9:5]};
      3:       return {bus.src2_value[63:32], bus.src2_tag[9:5]};
      default: return {bus.jalr_value_out,    bus.jalr_tag_out};
    endcase
  endfunction

  task automatic model_update(input vec_t v, input logic rst);
    bit clr;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin mval[r] = 32'd0; mtag[r] = 5'h1F; end
    end else if (v.rdy) begin
      for (int r = 1; r < 32; r++) begin
        clr = 1'b0;
        for (int c = 0; c < 2; c++)
          if (v.cv[c] && v.crd[c] == r && mtag[r] == v.ctag[c]) clr = 1'b1;
        for (int c = 0; c < 2; c++)
          if (v.cv[c] && v.crd[c] == r) mval[r] = v.cval[c];
        if (v.flush) mtag[r] = 5'h1F;
        else begin
          if (clr) mtag[r] = 5'h1F;
          for (int j = 0; j < 2; j++)
            if (v.dv[j] && v.drd[j] == r) mtag[r] = v.dtag[j];
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got value=%h tag=%h, expected value=%h tag=%h",
               name, act[36:5], act[4:0], exp[36:5], exp[4:0]);
    end
  endtask

  task automatic drive(input vec_t v, input logic rst);
    rst_in       = rst;
    bus.rdy_in   = v.rdy;
    bus.flush_in = v.flush;
    for (int c = 0; c < 2; c++) begin
      bus.cmt_valid[c]        = v.cv[c];
      bus.cmt_rd[c*5 +: 5]    = v.crd[c];
      bus.cmt_value[c*32 +: 32] = v.cval[c];
      bus.cmt_tag[c*5 +: 5]   = v.ctag[c];
      bus.disp_valid[c]       = v.dv[c];
      bus.disp_rd[c*5 +: 5]   = v.drd[c];
      bus.disp_rs1[c*5 +: 5]  = v.rs1[c];
      bus.disp_rs2[c*5 +: 5]  = v.rs2[c];
      bus.disp_tag[c*5 +: 5]  = v.dtag[c];
    end
    bus.jalr_rs_in = v.jrs;
  endtask

  task automatic cycle(input vec_t v, input logic rst, input bit mchk, input bit tchk, input string name);
    drive(v, rst);
    #3;
    if (mchk)
      for (int s = 0; s < 5; s++) check($sformatf("%s_model_sel%0d", name, s), dut_out(s), model_out(v, s));
    if (tchk) check(name, dut_out(v.sel), {v.ev, v.et});
    @(posedge clk_in);
    model_update(v, rst);
    #1;
  endtask

  initial begin
    vec_t v;
    for (int r = 0; r < 32; r++) begin mval[r] = 32'd0; mtag[r] = 5'h1F; end
    cycle(blank(), 1'b1, 1'b0, 1'b0, "rst0");
    cycle(blank(), 1'b1, 1'b1, 1'b0, "rst1");

    v = blank(); v.rs1[0] = 5'd5; v.sel = 0; tbl.push_back(v);
    v = blank(); v.jrs = 5'd5; v.sel = 4; tbl.push_back(v);
    v = blank(); v.dv[0] = 1'b1; v.drd[0] = 5'd3; v.dtag[0] = 5'd2; v.rs1[1] = 5'd3; v.sel = 2; v.et = 5'd2; tbl.push_back(v);
    v = blank(); v.rs1[0] = 5'd3; v.sel = 0; v.et = 5'd2; tbl.push_back(v);
    v = blank(); v.cv[0] = 1'b1; v.crd[0] = 5'd3; v.cval[0] = 32'hDEAD; v.ctag[0] = 5'd2;
    v.rs1[0] = 5'd3; v.sel = 0; v.ev = 32'hDEAD; tbl.push_back(v);
    v = blank(); v.rs1[0] = 5'd3; v.sel = 0; v.ev = 32'hDEAD; tbl.push_back(v);
    v = blank(); v.dv[0] = 1'b1; v.drd[0] = 5'd3; v.dtag[0] = 5'd2; v.jrs = 5'd3; v.sel = 4; v.ev = 32'hDEAD; tbl.push_back(v);
    v = blank(); v.cv[0] = 1'b1; v.crd[0] = 5'd3; v.cval[0] = 32'hBEEF; v.ctag[0] = 5'd2;
    v.dv[0] = 1'b1; v.drd[0] = 5'd3; v.dtag[0] = 5'd7; v.rs1[0] = 5'd3; v.sel = 0; v.ev = 32'hBEEF; tbl.push_back(v);
    v = blank(); v.rs1[0] = 5'd3; v.sel = 0; v.ev = 32'hBEEF; v.et = 5'd7; tbl.push_back(v);
    v = blank(); v.cv[0] = 1'b1; v.crd[0] = 5'd3; v.cval[0] = 32'h1234; v.ctag[0] = 5'd2;
    v.jrs = 5'd3; v.sel = 4; v.ev = 32'h1234; v.et = 5'd7; tbl.push_back(v);
    v = blank(); v.rs2[1] = 5'd3; v.sel = 3; v.ev = 32'h1234; v.et = 5'd7; tbl.push_back(v);
    v = blank(); v.cv[0] = 1'b1; v.cv[1] = 1'b1; v.crd[0] = 5'd4; v.crd[1] = 5'd4;
    v.cval[0] = 32'h11; v.cval[1] = 32'h22; v.ctag[0] = 5'd3; v.ctag[1] = 5'd3;
    v.rs2[0] = 5'd4; v.sel = 1; v.ev = 32'h22; tbl.push_back(v);
    v = blank(); v.dv[0] = 1'b1; v.dv[1] = 1'b1; v.drd[0] = 5'd4; v.drd[1] = 5'd4;
    v.dtag[0] = 5'd1; v.dtag[1] = 5'd6; v.rs1[1] = 5'd4; v.sel = 2; v.et = 5'd1; tbl.push_back(v);
    v = blank(); v.rs2[0] = 5'd4; v.sel = 1; v.ev = 32'h22; v.et = 5'd6; tbl.push_back(v);
    v = blank(); v.flush = 1'b1; v.cv[0] = 1'b1; v.crd[0] = 5'd8; v.cval[0] = 32'h55;
    v.dv[0] = 1'b1; v.drd[0] = 5'd9; v.dtag[0] = 5'd5; v.rs1[0] = 5'd8; v.sel = 0; v.ev = 32'h55; tbl.push_back(v);
    v = blank(); v.rs1[0] = 5'd8; v.sel = 0; v.ev = 32'h55; tbl.push_back(v);
    v = blank(); v.rs2[0] = 5'd4; v.sel = 1; v.ev = 32'h22; tbl.push_back(v);
    v = blank(); v.rs1[1] = 5'd9; v.sel = 2; tbl.push_back(v);
    v = blank(); v.jrs = 5'd3; v.sel = 4; v.ev = 32'h1234; tbl.push_back(v);
    v = blank(); v.rdy = 1'b0; v.cv[0] = 1'b1; v.crd[0] = 5'd10; v.cval[0] = 32'h77;
    v.dv[0] = 1'b1; v.drd[0] = 5'd10; v.dtag[0] = 5'd4; v.rs1[0] = 5'd10; v.sel = 0; v.ev = 32'h77; tbl.push_back(v);
    v = blank(); v.rs1[0] = 5'd10; v.sel = 0; tbl.push_back(v);
    v = blank(); v.cv[0] = 1'b1; v.crd[0] = 5'd0; v.cval[0] = 32'h99;
    v.dv[0] = 1'b1; v.drd[0] = 5'd0; v.dtag[0] = 5'd3; v.rs1[1] = 5'd0; v.sel = 2; tbl.push_back(v);
    v = blank(); v.jrs = 5'd0; v.sel = 4; tbl.push_back(v);
    v = blank(); v.rs2[1] = 5'd0; v.sel = 3; tbl.push_back(v);

    foreach (tbl[i]) cycle(tbl[i], 1'b0, 1'b1, 1'b1, $sformatf("vec%0d", i));

    // Reset must win over a held (rdy low) cycle.
    v = blank(); v.dv[0] = 1'b1; v.drd[0] = 5'd5; v.dtag[0] = 5'd4;
    v.cv[0] = 1'b1; v.crd[0] = 5'd6; v.cval[0] = 32'hAB; v.ctag[0] = 5'd3;
    cycle(v, 1'b0, 1'b1, 1'b0, "seed_x5_x6");
    v = blank(); v.rdy = 1'b0; v.rs1[0] = 5'd5; v.rs2[0] = 5'd6; v.sel = 0; v.et = 5'd4;
    cycle(v, 1'b0, 1'b1, 1'b1, "hold_x5");
    v = blank(); v.rdy = 1'b0; v.rs2[0] = 5'd6; v.sel = 1; v.ev = 32'hAB;
    cycle(v, 1'b1, 1'b1, 1'b1, "pre_rst_x6");
    v = blank(); v.rs1[0] = 5'd5; v.rs2[0] = 5'd6; v.sel = 0;
    cycle(v, 1'b0, 1'b1, 1'b1, "rst_rdy0_x5");
    v.sel = 1;
    cycle(v, 1'b0, 1'b1, 1'b1, "rst_rdy0_x6");

    for (int n = 0; n < 600; n++) cycle(rnd(), ($urandom_range(63) == 0), 1'b1, 1'b0, $sformatf("rnd%0d", n));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
